lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store unit for the MEM stage of the pipelined RV32I core. It sits between the EX/MEM pipeline register and `data_mem`, and translates RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide `data_mem` accesses. Sub-word stores are done as read-modify-write. Sign and zero extension of load data is handled here. Misaligned and word-crossing accesses are split into multiple accesses, or trapped, depending on configuration.

## Interface
Parameters:
- `XLEN`, 32, data and address width. The core uses only 32.

Ports:
- `i_clk`  in  1  rising-edge clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  1  a memory instruction is in the MEM stage.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_funct3`  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `i_req_addr`  in  XLEN  byte address.
- `i_req_wdata`  in  XLEN  store data, right-aligned.
- `o_stall`  out  1  hold the pipeline; the unit needs another cycle.
- `o_load_valid`  out  1  `o_load_data` is valid this cycle.
- `o_load_data`  out  XLEN  extended load result.
- `o_misalign`  out  1  misaligned-access exception pulse.
- `o_mem_we`  out  1  to `data_mem` `i_we`.
- `o_mem_add`  out  XLEN  to `data_mem` `i_add`, always word-aligned (bits [1:0] = 0).
- `i_mem_data`  in  XLEN  from `data_mem` `o_data`. Read is combinational.
- `o_mem_data`  out  XLEN  to `data_mem` `i_data`. `data_mem` writes on the rising edge when `o_mem_we` = 1.

## Operation
- Memory is little-endian. Byte lane k = addr[1:0].
- Requests are captured into `r_addr`, `r_funct3`, `r_we`, `r_wdata` on the first cycle. Later cycles use only the captured values, so request changes while `o_stall` = 1 are ignored.
- Invalid funct3 (011, 110, 111, or 1xx with store): no-op. No write, `o_load_valid` = 0, `o_misalign` = 0.
- Load extension:
  - LB, LH: sign-extend from bit 7 or bit 15.
  - LBU, LHU: zero-extend.

FSM states: `S_IDLE`, `S_RMW_WR`, `S_LD_HI`, `S_ST_LO_WR`, `S_ST_HI_RD`, `S_ST_HI_WR`.
- Aligned LW/SW, or any load contained in one word: served entirely in `S_IDLE`. One cycle, no stall.
- SB, or SH within one word:
  - `S_IDLE` reads the aligned word, captures it in `r_word`, asserts stall.
  - `S_RMW_WR` writes the merged word, stall = 0.
- Word-crossing load (`_EN` only):
  - `S_IDLE` reads the low word into `r_word`, stall.
  - `S_LD_HI` reads the word at +4, combines both, asserts `o_load_valid`, stall = 0.
- Word-crossing store (`_EN` only):
  - `S_IDLE` reads the low word, stall.
  - `S_ST_LO_WR` writes the low word merged, stall.
  - `S_ST_HI_RD` reads the high word, stall.
  - `S_ST_HI_WR` writes the high word merged, stall = 0.
- High-word address = low-word address + 4, mod 2^32. This wraps 0xFFFFFFFC to 0x00000000.

## Timing
- Reset state: FSM `S_IDLE`, `r_*` = 0. While `i_rst` = 1, outputs are `o_stall`, `o_mem_we`, `o_load_valid`, `o_misalign` = 0, `o_load_data` = 0, `o_mem_data` = 0.
- Cycles per request:
  - Aligned access: 1.
  - Sub-word store: 2.
  - Crossing load: 2.
  - Crossing store: 4.
- `o_stall` is 1 on every cycle of a request except the last.
- `o_load_valid` is high only on the last cycle of a load.
- Reset in mid-operation: the next state is `S_IDLE` and no further writes occur. A low word already written stays written.
- `i_req_valid` = 0 in `S_IDLE`: `o_mem_we` = 0 and outputs are idle. `o_mem_add` still follows the aligned `i_req_addr`.

## Configuration
- `LSU_MISALIGN_EN` defined:
  - Misaligned accesses within one word complete as normal loads or RMW stores.
  - Word-crossing accesses split as described above.
  - `o_misalign` is tied to 0.
- Not defined:
  - Any access that is not naturally aligned (H with addr[0] = 1; W with addr[1:0] ≠ 0) raises `o_misalign` = 1 for one cycle.
  - That cycle has no write, `o_load_valid` = 0, and `o_stall` = 0.
  - States `S_LD_HI`, `S_ST_*` are not built.

## Structure
- `lsu_pkg`: funct3 constants (`F3_LB`…`F3_SW`), FSM state enum.
- Sub-module `lsu_lane_mux` (combinational):
  - Byte-enable generation.
  - Store-data lane shift and merge into a word.
  - Load extraction and extension across two words.

## Test plan
1. SW 0x100 ← 0xDEADBEEF, then LW 0x100 → 0xDEADBEEF. No stall; `o_mem_we` high for exactly one cycle.
2. SB 0x101 ← 0x55: one stall cycle, word becomes 0xDEAD55EF. Then:
   - LB 0x101 → 0x00000055.
   - LB 0x103 → 0xFFFFFFDE.
   - LBU 0x103 → 0x000000DE.
3. With `_EN`, words 0x104 and 0x108 = 0. SW 0x106 ← 0x11223344:
   - `o_stall` = 1,1,1,0.
   - Result: mem[0x104] = 0x33440000, mem[0x108] = 0x00001122.
   - Then LW 0x106 → 0x11223344 after one stall cycle.
4. Without `_EN`, LH 0x103 → `o_misalign` = 1, `o_mem_we` = 0, `o_stall` = 0, `o_load_valid` = 0.
5. With `_EN`, crossing store, `i_rst` asserted while in `S_ST_HI_RD`:
   - Next cycle `o_stall` = 0 and the FSM is idle.
   - mem[hi] is unchanged; mem[lo] holds the merged value.
6. With `_EN`, LW 0xFFFFFFFE → `o_mem_add` sequence 0xFFFFFFFC then 0x00000000, and the result combines bytes from both words.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM states and access-geometry helpers for lsu_mem_ctrl
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RMW_WR,
    S_LD_HI,
    S_ST_LO_WR,
    S_ST_HI_RD,
    S_ST_HI_WR
  } lsu_state_t;

  function automatic logic f3_valid(input logic [2:0] f3, input logic we);
    case (f3)
      F3_LB, F3_LH, F3_LW: return 1'b1;
      F3_LBU, F3_LHU:      return !we;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] acc_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
    return ({1'b0, off} + acc_bytes(f3)) > 3'd4;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// rtl/lsu_lane_mux.sv - byte enables, store lane shift/merge and two-word load extraction
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_word,
  input  logic        i_sel_hi,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [3:0]  mask;
  logic [7:0]  be;
  logic [63:0] sdata;
  logic [31:0] ldw;
  logic [3:0]  be_w;
  logic [31:0] sd_w;

  // Byte enables and store data span two words so a crossing access maps onto {hi, lo}
  always_comb begin
    case (i_funct3[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be    = {4'b0000, mask} << i_off;
    sdata = {32'd0, i_wdata} << {i_off, 3'b000};
    ldw   = 32'({i_hi, i_lo} >> {i_off, 3'b000});
    be_w  = i_sel_hi ? be[7:4] : be[3:0];
    sd_w  = i_sel_hi ? sdata[63:32] : sdata[31:0];
  end

  always_comb begin
    o_merged = i_word;
    for (int k = 0; k < 4; k++) begin
      if (be_w[k]) o_merged[8*k +: 8] = sd_w[8*k +: 8];
    end
  end

  always_comb begin
    case (i_funct3)
      F3_LB:   o_load_data = {{24{ldw[7]}}, ldw[7:0]};
      F3_LH:   o_load_data = {{16{ldw[15]}}, ldw[15:0]};
      F3_LW:   o_load_data = ldw;
      F3_LBU:  o_load_data = {24'd0, ldw[7:0]};
      F3_LHU:  o_load_data = {16'd0, ldw[15:0]};
      default: o_load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I MEM-stage load/store unit; LSU_MISALIGN_EN enables split misaligned access
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_stall,
  output logic            o_load_valid,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_misalign,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_add,
  input  logic [XLEN-1:0] i_mem_data,
  output logic [XLEN-1:0] o_mem_data
);

  lsu_state_t      state, state_nxt;
  logic [XLEN-1:0] r_addr, r_wdata, r_word;
  logic [2:0]      r_funct3;
  logic            r_we;

  logic            idle;
  logic [XLEN-1:0] cur_addr, cur_wdata, lo_add, hi_add;
  logic [2:0]      cur_funct3;
  logic [XLEN-1:0] mux_load, mux_merged;

  // In S_IDLE the live request drives everything; later cycles see only captured fields
  assign idle       = (state == S_IDLE);
  assign cur_addr   = idle ? i_req_addr   : r_addr;
  assign cur_wdata  = idle ? i_req_wdata  : r_wdata;
  assign cur_funct3 = idle ? i_req_funct3 : r_funct3;
  assign lo_add     = {cur_addr[XLEN-1:2], 2'b00};
  assign hi_add     = lo_add + XLEN'(4);

  lsu_lane_mux u_lane_mux (
    .i_off       (cur_addr[1:0]),
    .i_funct3    (cur_funct3),
    .i_wdata     (cur_wdata),
    .i_lo        ((state == S_LD_HI) ? r_word : i_mem_data),
    .i_hi        (i_mem_data),
    .i_word      (r_word),
    .i_sel_hi    (state == S_ST_HI_WR),
    .o_load_data (mux_load),
    .o_merged    (mux_merged)
  );

  always_comb begin
    state_nxt    = state;
    o_stall      = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_add    = lo_add;
    o_mem_data   = '0;
    o_load_valid = 1'b0;
    o_load_data  = '0;
    o_misalign   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_req_valid && f3_valid(i_req_funct3, i_req_we)) begin
`ifdef LSU_MISALIGN_EN
          if (!i_req_we) begin
            if (crosses(i_req_funct3, i_req_addr[1:0])) begin
              o_stall   = 1'b1;
              state_nxt = S_LD_HI;
            end else begin
              o_load_valid = 1'b1;
              o_load_data  = mux_load;
            end
          end else if (crosses(i_req_funct3, i_req_addr[1:0])) begin
            o_stall   = 1'b1;
            state_nxt = S_ST_LO_WR;
          end else if (i_req_funct3 == F3_SW) begin
            o_mem_we   = 1'b1;
            o_mem_data = i_req_wdata;
          end else begin
            o_stall   = 1'b1;
            state_nxt = S_RMW_WR;
          end
`else
          if (misaligned(i_req_funct3, i_req_addr[1:0])) begin
            o_misalign = 1'b1;
          end else if (!i_req_we) begin
            o_load_valid = 1'b1;
            o_load_data  = mux_load;
          end else if (i_req_funct3 == F3_SW) begin
            o_mem_we   = 1'b1;
            o_mem_data = i_req_wdata;
          end else begin
            o_stall   = 1'b1;
            state_nxt = S_RMW_WR;
          end
`endif
        end
      end
      S_RMW_WR: begin
        o_mem_we   = r_we;
        o_mem_data = mux_merged;
        state_nxt  = S_IDLE;
      end
`ifdef LSU_MISALIGN_EN
      S_LD_HI: begin
        o_mem_add    = hi_add;
        o_load_valid = 1'b1;
        o_load_data  = mux_load;
        state_nxt    = S_IDLE;
      end
      S_ST_LO_WR: begin
        o_mem_we   = r_we;
        o_mem_data = mux_merged;
        o_stall    = 1'b1;
        state_nxt  = S_ST_HI_RD;
      end
      S_ST_HI_RD: begin
        o_mem_add = hi_add;
        o_stall   = 1'b1;
        state_nxt = S_ST_HI_WR;
      end
      S_ST_HI_WR: begin
        o_mem_add  = hi_add;
        o_mem_we   = r_we;
        o_mem_data = mux_merged;
        state_nxt  = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
    // Reset must suppress any write, including one mid-way through a split store
    if (i_rst) begin
      o_stall      = 1'b0;
      o_mem_we     = 1'b0;
      o_mem_data   = '0;
      o_load_valid = 1'b0;
      o_load_data  = '0;
      o_misalign   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (idle && i_req_valid) begin
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_funct3 <= i_req_funct3;
        r_we     <= i_req_we;
        r_word   <= i_mem_data;
      end
      if (state == S_ST_HI_RD) r_word <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed vector bench for lsu_mem_ctrl with a behavioural data_mem
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, load_valid, misalign, mem_we;
  logic [31:0] load_data, mem_add, mem_rdata, mem_wdata;

  logic [31:0] mem [0:255] = '{default: 32'd0};
  logic        bd_en = 1'b0;
  logic [31:0] bd_addr = 32'd0, bd_data = 32'd0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.XLEN(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_stall      (stall),
    .o_load_valid (load_valid),
    .o_load_data  (load_data),
    .o_misalign   (misalign),
    .o_mem_we     (mem_we),
    .o_mem_add    (mem_add),
    .i_mem_data   (mem_rdata),
    .o_mem_data   (mem_wdata)
  );

  assign mem_rdata = mem[mem_add[9:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_add[9:2]] <= mem_wdata;
    if (bd_en)  mem[bd_addr[9:2]] <= bd_data;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
    int          wecnt;
    logic        lv;
    logic [31:0] ld;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int cyc, input int wecnt,
                         input logic lv, input logic [31:0] ld, input logic mis);
    vec_t v;
    v = '{we, f3, addr, wdata, cyc, wecnt, lv, ld, mis};
    vecs.push_back(v);
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    bd_en = 1'b1; bd_addr = addr; bd_data = data;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  // Entered and left at posedge+1; garbage inputs while stalled must be ignored
  task automatic run_req(input vec_t v, output int cyc, output int wecnt, output int lvcnt,
                         output int miscnt, output logic [31:0] ld, output logic [31:0] adds [8]);
    logic st;
    cyc = 0; wecnt = 0; lvcnt = 0; miscnt = 0; ld = 32'd0;
    for (int k = 0; k < 8; k++) adds[k] = 32'd0;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    for (int c = 0; c < 8; c++) begin
      #3;
      adds[c] = mem_add;
      cyc++;
      if (mem_we) wecnt++;
      if (load_valid) begin lvcnt++; ld = load_data; end
      if (misalign) miscnt++;
      st = stall;
      @(posedge clk); #1;
      if (!st) break;
      req_we = ~v.we; req_funct3 = v.f3 ^ 3'b001; req_addr = ~v.addr; req_wdata = ~v.wdata;
    end
    req_valid = 1'b0;
  endtask

  task automatic run_check(input string name, input vec_t v, output logic [31:0] adds [8]);
    int cyc, wecnt, lvcnt, miscnt;
    logic [31:0] ld;
    run_req(v, cyc, wecnt, lvcnt, miscnt, ld, adds);
    check32({name, " cycles"}, cyc, v.cyc);
    check32({name, " writes"}, wecnt, v.wecnt);
    check32({name, " load_valid count"}, lvcnt, v.lv ? 1 : 0);
    if (v.lv) check32({name, " load_data"}, ld, v.ld);
    check32({name, " misalign count"}, miscnt, v.mis ? 1 : 0);
    check32({name, " first mem_add"}, adds[0], {v.addr[31:2], 2'b00});
  endtask

  initial begin
    logic [31:0] adds [8];
    vec_t v;

    // Sequential table: each row sees the memory left by the rows above it
    add_vec(1, F3_SW,  32'h100, 32'hDEADBEEF, 1, 1, 0, 32'h0, 0);
    add_vec(0, F3_LW,  32'h100, 32'h0,        1, 0, 1, 32'hDEADBEEF, 0);
    add_vec(1, F3_SB,  32'h101, 32'hAAAAAA55, 2, 1, 0, 32'h0, 0);
    add_vec(0, F3_LW,  32'h100, 32'h0,        1, 0, 1, 32'hDEAD55EF, 0);
    add_vec(0, F3_LB,  32'h101, 32'h0,        1, 0, 1, 32'h00000055, 0);
    add_vec(0, F3_LB,  32'h103, 32'h0,        1, 0, 1, 32'hFFFFFFDE, 0);
    add_vec(0, F3_LBU, 32'h103, 32'h0,        1, 0, 1, 32'h000000DE, 0);
    add_vec(0, F3_LH,  32'h102, 32'h0,        1, 0, 1, 32'hFFFFDEAD, 0);
    add_vec(0, F3_LHU, 32'h102, 32'h0,        1, 0, 1, 32'h0000DEAD, 0);
    add_vec(0, F3_LH,  32'h100, 32'h0,        1, 0, 1, 32'h000055EF, 0);
    add_vec(1, F3_SH,  32'h102, 32'hFFFF1234, 2, 1, 0, 32'h0, 0);
    add_vec(0, F3_LW,  32'h100, 32'h0,        1, 0, 1, 32'h123455EF, 0);
    add_vec(1, 3'b100, 32'h100, 32'h0,        1, 0, 0, 32'h0, 0);
    add_vec(0, 3'b011, 32'h100, 32'h0,        1, 0, 0, 32'h0, 0);
    add_vec(0, 3'b110, 32'h100, 32'h0,        1, 0, 0, 32'h0, 0);
    add_vec(0, F3_LH,  32'h103, 32'h0,        EN ? 2 : 1, 0, EN, 32'h00000012, !EN);
    add_vec(0, F3_LW,  32'h102, 32'h0,        EN ? 2 : 1, 0, EN, 32'h00001234, !EN);
    add_vec(1, F3_SW,  32'h101, 32'h99887766, EN ? 4 : 1, EN ? 2 : 0, 0, 32'h0, !EN);
    add_vec(0, F3_LW,  32'h100, 32'h0,        1, 0, 1, EN ? 32'h887766EF : 32'h123455EF, 0);
    add_vec(0, F3_LHU, 32'h101, 32'h0,        1, 0, EN, 32'h00007766, !EN);
    add_vec(1, F3_SB,  32'h103, 32'h00000080, 2, 1, 0, 32'h0, 0);
    add_vec(0, F3_LB,  32'h103, 32'h0,        1, 0, 1, 32'hFFFFFF80, 0);

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0;
    @(posedge clk); #1;
    poke(32'h100, 32'h00000080);

    // Outputs must stay quiet while reset is held, whatever the request
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h100; req_wdata = 32'hFFFFFFFF;
    #3;
    check32("reset stall", stall, 0);
    check32("reset mem_we", mem_we, 0);
    check32("reset mem_data", mem_wdata, 0);
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = F3_LB;
    #3;
    check32("reset load_valid", load_valid, 0);
    check32("reset load_data", load_data, 0);
    @(posedge clk); #1;
    req_funct3 = F3_LH; req_addr = 32'h101;
    #3;
    check32("reset misalign", misalign, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; req_addr = 32'h123;
    #3;
    check32("idle mem_add", mem_add, 32'h120);
    check32("idle mem_we", mem_we, 0);
    check32("idle stall", stall, 0);
    check32("idle load_valid", load_valid, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_check($sformatf("v%0d", i), vecs[i], adds);
    check32("mem 0x100 after table", mem[8'h40], EN ? 32'h807766EF : 32'h803455EF);
    check32("mem 0x104 after table", mem[8'h41], EN ? 32'h00000099 : 32'h00000000);

    // Reset during the write cycle of a sub-word RMW store
    poke(32'h120, 32'h11111111);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SB; req_addr = 32'h121; req_wdata = 32'h22;
    #3;
    check32("rmw-reset first stall", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    check32("rmw-reset mem_we", mem_we, 0);
    check32("rmw-reset stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    check32("rmw-reset mem 0x120", mem[8'h48], 32'h11111111);
    v = '{0, F3_LW, 32'h120, 32'h0, 1, 0, 1, 32'h11111111, 0};
    run_check("post-reset LW", v, adds);

`ifdef LSU_MISALIGN_EN
    poke(32'h104, 32'h0);
    poke(32'h108, 32'h0);
    v = '{1, F3_SW, 32'h106, 32'h11223344, 4, 2, 0, 32'h0, 0};
    run_check("cross SW", v, adds);
    check32("cross SW add1", adds[1], 32'h104);
    check32("cross SW add2", adds[2], 32'h108);
    check32("cross SW add3", adds[3], 32'h108);
    check32("cross SW lo", mem[8'h41], 32'h33440000);
    check32("cross SW hi", mem[8'h42], 32'h00001122);
    v = '{0, F3_LW, 32'h106, 32'h0, 2, 0, 1, 32'h11223344, 0};
    run_check("cross LW", v, adds);

    poke(32'h10C, 32'hA0A0A0A0);
    poke(32'h110, 32'hB0B0B0B0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h10F; req_wdata = 32'hCAFEF00D;
    #3;
    check32("cs-reset c1 stall", stall, 1);
    @(posedge clk); #1;
    #3;
    check32("cs-reset lo we", mem_we, 1);
    check32("cs-reset lo data", mem_wdata, 32'h0DA0A0A0);
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    check32("cs-reset rst stall", stall, 0);
    check32("cs-reset rst we", mem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    #3;
    check32("cs-reset idle stall", stall, 0);
    check32("cs-reset idle we", mem_we, 0);
    @(posedge clk); #1;
    check32("cs-reset mem lo", mem[8'h43], 32'h0DA0A0A0);
    check32("cs-reset mem hi", mem[8'h44], 32'hB0B0B0B0);
    v = '{0, F3_LW, 32'h110, 32'h0, 1, 0, 1, 32'hB0B0B0B0, 0};
    run_check("cs-reset LW", v, adds);

    poke(32'hFFFFFFFC, 32'hAABBCCDD);
    poke(32'h0, 32'h44332211);
    v = '{0, F3_LW, 32'hFFFFFFFE, 32'h0, 2, 0, 1, 32'h2211AABB, 0};
    run_check("wrap LW", v, adds);
    check32("wrap LW add1", adds[1], 32'h00000000);
`else
    v = '{0, F3_LH, 32'h103, 32'h0, 1, 0, 0, 32'h0, 1};
    run_check("mis LH", v, adds);
    v = '{1, F3_SH, 32'h121, 32'h5555, 1, 0, 0, 32'h0, 1};
    run_check("mis SH", v, adds);
    check32("mis SH mem", mem[8'h48], 32'h11111111);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
